// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle processor: sequences processor reset,
// counts RUN cycles, detects halt (PC stuck) or cycle-budget timeout and
// reports the outcome. Restartable from IDLE or DONE.
module cpu_run_controller #(
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1024,
  parameter int HALT_REPEAT  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PC_WIDTH-1:0]  cpu_pc,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  final_pc
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam logic [HW-1:0]        HOLD_INIT = HW'(RESET_CYCLES - 1);
  localparam logic [RW-1:0]        REP_LAST  = RW'(HALT_REPEAT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET_HOLD, S_RUN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [HW-1:0]         r_hold_cnt;
  logic [RW-1:0]         r_rep_cnt;
  logic [PC_WIDTH-1:0]   r_prev_pc;
  logic                  r_pc_valid;
  logic                  r_cpu_reset, r_busy, r_done, r_halted, r_timeout;
  logic [CNT_WIDTH-1:0]  r_cycle_count;
  logic [PC_WIDTH-1:0]   r_final_pc;
  logic                  w_start_run, w_pc_same, w_halt, w_tmo;
  logic                  w_cpu_reset_nxt, w_busy_nxt, w_done_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;

  // A new run may begin only from IDLE or DONE, and abort always wins.
  assign w_start_run = (r_state == S_IDLE || r_state == S_DONE) && start && !abort;
  // prev_pc is meaningless on the first RUN cycle, hence the valid qualifier.
  assign w_pc_same   = r_pc_valid && (cpu_pc == r_prev_pc);
  assign w_halt      = (r_state == S_RUN) && w_pc_same && (r_rep_cnt == REP_LAST);
  assign w_tmo       = (r_state == S_RUN) && (r_cycle_count == CNT_LAST);
  assign w_cnt_inc   = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort returns to IDLE from any active state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (w_start_run) w_state_nxt = S_RESET_HOLD;
      S_RESET_HOLD: if (abort) w_state_nxt = S_IDLE;
                    else if (r_hold_cnt == '0) w_state_nxt = S_RUN;
      S_RUN:        if (abort) w_state_nxt = S_IDLE;
                    else if (w_halt || w_tmo) w_state_nxt = S_DONE;
      S_DONE:       if (abort) w_state_nxt = S_IDLE;
                    else if (w_start_run) w_state_nxt = S_RESET_HOLD;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    w_cpu_reset_nxt = (w_state_nxt != S_RUN);
    w_busy_nxt      = (w_state_nxt == S_RESET_HOLD) || (w_state_nxt == S_RUN);
    w_done_nxt      = (w_state_nxt == S_DONE);
  end

  // Registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cpu_reset <= w_cpu_reset_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Run datapath: hold counter, cycle counter, PC repeat tracking, result capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hold_cnt    <= '0;
      r_rep_cnt     <= '0;
      r_prev_pc     <= '0;
      r_pc_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_final_pc    <= '0;
    end else if (w_start_run) begin
      r_hold_cnt    <= HOLD_INIT;
      r_rep_cnt     <= '0;
      r_pc_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_final_pc    <= '0;
    end else if (!abort) begin
      if (r_state == S_RESET_HOLD && r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
      if (r_state == S_RUN) begin
        r_cycle_count <= w_cnt_inc;
        r_prev_pc     <= cpu_pc;
        r_pc_valid    <= 1'b1;
        r_rep_cnt     <= w_pc_same ? r_rep_cnt + 1'b1 : '0;
        // Halt takes precedence when both end conditions hit on one edge.
        if (w_halt) begin
          r_halted   <= 1'b1;
          r_final_pc <= cpu_pc;
        end else if (w_tmo) begin
          r_timeout  <= 1'b1;
          r_final_pc <= cpu_pc;
        end
      end
    end
  end

  assign cpu_reset   = r_cpu_reset;
  assign busy        = r_busy;
  assign done        = r_done;
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;
  assign final_pc    = r_final_pc;

endmodule
